// File: rtl/gpu_pkg.sv
// Shared constants, register map, command codes and executor states for the GPU CPU-write front end.
// Optional hardware clear sweep is controlled by the GPU_CLEAR_EN macro in gpu_cpu_writer.
// next_cell() is the single place where cursor wrap-around at the end of the screen is defined.
package gpu_pkg;

  localparam int CELLS      = 7500;
  localparam int ADDR_W     = 13;
  localparam int DATA_W     = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int CMD_W      = 6;

  localparam logic [1:0] REG_CHAR = 2'd0;
  localparam logic [1:0] REG_LOAD = 2'd1;
  localparam logic [1:0] REG_CMD  = 2'd2;
  localparam logic [1:0] REG_FILL = 2'd3;

  localparam logic [3:0] CMD_CLEAR  = 4'h1;
  localparam logic [3:0] CMD_HOME   = 4'h2;
  localparam logic [3:0] CMD_SETCUR = 4'h3;
  localparam logic [3:0] CMD_CLROVF = 4'h4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // Advance a cell index, wrapping the last visible cell back to 0.
  function automatic logic [ADDR_W-1:0] next_cell(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(CELLS - 1)) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Small synchronous command FIFO holding {register select, data nibble} entries.
// Latency: a push is visible at the head on the next cycle; pop consumes the head immediately.
// Backpressure: pushes while full are ignored (the caller flags the drop); pops while empty are ignored.
module gpu_cmd_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp;
  logic [AW:0]  r_rp;
  logic         w_do_push;
  logic         w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty   = (r_wp == r_rp);
  assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dat     = r_mem[r_rp[AW-1:0]];

  // Pointer update; fullness is judged before this cycle's pop, so a push on a full FIFO is lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wp[AW-1:0]] <= i_dat;
  end

endmodule

// File: rtl/gpu_cpu_writer.sv
// CPU-side framebuffer write front end: syncs 6502 strobes, queues register writes, executes them as FB writes.
// Latency: push 3 cycles after CE falls; FB_WE rises 2 cycles after the push (pop, then request).
// Backpressure: FB_WE held with stable address/data until FB_GNT; a push into a full FIFO is dropped and sets OVERFLOW.
// Macro GPU_CLEAR_EN builds the hardware clear-screen sweep; without it command 0x1 is a no-op.
module gpu_cpu_writer
  import gpu_pkg::*;
(
  input  logic              CLK_PIXEL,
  input  logic              RST,
  input  logic              CE,
  input  logic              RW,
  input  logic [1:0]        ADDR,
  input  logic [3:0]        DATA,
  output logic [ADDR_W-1:0] FB_ADDR,
  output logic [DATA_W-1:0] FB_DATA,
  output logic              FB_WE,
  input  logic              FB_GNT,
  output logic              BUSY,
  output logic              OVERFLOW
);

  logic [1:0]        r_ce_q;
  logic [1:0]        r_rw_q;
  logic [1:0]        r_addr_q1, r_addr_q2;
  logic [3:0]        r_data_q1, r_data_q2;
  logic              r_wr_d;
  logic              w_wr;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CMD_W-1:0]  w_head;
  logic              w_clr_ovf;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cursor;
  logic [ADDR_W-1:0] r_load;
  logic [DATA_W-1:0] r_fill;
  logic [ADDR_W-1:0] r_fb_addr;
  logic [DATA_W-1:0] r_fb_data;
  logic              r_fb_we;
  logic              r_ovf;
`ifdef GPU_CLEAR_EN
  logic [ADDR_W-1:0] r_sweep;
`else
  logic              w_unused_fill;
  assign w_unused_fill = ^r_fill;
`endif

  // Two-flop synchronisers; strobes reset to their inactive (high) level so reset cannot fake a write.
  always_ff @(posedge CLK_PIXEL or negedge RST) begin
    if (!RST) begin
      r_ce_q    <= 2'b11;
      r_rw_q    <= 2'b11;
      r_addr_q1 <= '0;
      r_addr_q2 <= '0;
      r_data_q1 <= '0;
      r_data_q2 <= '0;
      r_wr_d    <= 1'b0;
    end else begin
      r_ce_q    <= {r_ce_q[0], CE};
      r_rw_q    <= {r_rw_q[0], RW};
      r_addr_q1 <= ADDR;
      r_addr_q2 <= r_addr_q1;
      r_data_q1 <= DATA;
      r_data_q2 <= r_data_q1;
      r_wr_d    <= w_wr;
    end
  end

  assign w_wr      = ~r_ce_q[1] & ~r_rw_q[1];
  assign w_push    = w_wr & ~r_wr_d;
  assign w_pop     = (r_state == IDLE) && !w_empty;
  assign w_clr_ovf = w_pop && (w_head[5:4] == REG_CMD) && (w_head[3:0] == CMD_CLROVF);

  gpu_cmd_fifo #(.W(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (CLK_PIXEL),
    .i_rst_n (RST),
    .i_push  (w_push),
    .i_dat   ({r_addr_q2, r_data_q2}),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sticky drop flag; a drop in the same cycle as a clear command wins so no drop goes unreported.
  always_ff @(posedge CLK_PIXEL or negedge RST) begin
    if (!RST)                  r_ovf <= 1'b0;
    else if (w_push && w_full) r_ovf <= 1'b1;
    else if (w_clr_ovf)        r_ovf <= 1'b0;
  end

  // Executor: decodes the FIFO head in IDLE and drives the registered framebuffer request.
  always_ff @(posedge CLK_PIXEL or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_cursor  <= '0;
      r_load    <= '0;
      r_fill    <= '0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
      r_fb_we   <= 1'b0;
`ifdef GPU_CLEAR_EN
      r_sweep   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            case (w_head[5:4])
              REG_CHAR: begin
                r_state   <= WRITE;
                r_fb_we   <= 1'b1;
                r_fb_addr <= r_cursor;
                r_fb_data <= w_head[DATA_W-1:0];
              end
              REG_LOAD: r_load <= {r_load[ADDR_W-5:0], w_head[3:0]};
              REG_CMD: begin
                case (w_head[3:0])
                  CMD_CLEAR: begin
`ifdef GPU_CLEAR_EN
                    r_state   <= CLEAR;
                    r_sweep   <= '0;
                    r_fb_we   <= 1'b1;
                    r_fb_addr <= '0;
                    r_fb_data <= r_fill;
`endif
                  end
                  CMD_HOME:   r_cursor <= '0;
                  CMD_SETCUR: r_cursor <= (r_load < ADDR_W'(CELLS)) ? r_load : '0;
                  default: ;
                endcase
              end
              default:  r_fill <= w_head[DATA_W-1:0];
            endcase
          end
        end
        WRITE: begin
          if (FB_GNT) begin
            r_cursor <= next_cell(r_cursor);
            r_fb_we  <= 1'b0;
            r_state  <= IDLE;
          end
        end
`ifdef GPU_CLEAR_EN
        CLEAR: begin
          if (FB_GNT) begin
            if (r_sweep == ADDR_W'(CELLS - 1)) begin
              r_cursor <= '0;
              r_fb_we  <= 1'b0;
              r_state  <= IDLE;
            end else begin
              r_sweep   <= r_sweep + 1'b1;
              r_fb_addr <= r_sweep + 1'b1;
            end
          end
        end
`endif
        default: begin
          r_fb_we <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign FB_ADDR  = r_fb_addr;
  assign FB_DATA  = r_fb_data;
  assign FB_WE    = r_fb_we;
  assign OVERFLOW = r_ovf;
  assign BUSY     = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_gpu_cpu_writer.sv
`timescale 1ns/1ps
module tb_gpu_cpu_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b1;
  logic        rw = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic [3:0]  data = 4'd0;
  logic        fb_gnt = 1'b0;
  logic        gnt_toggle = 1'b0;
  logic [12:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic        busy;
  logic        overflow;

  int tests = 0;
  int fails = 0;
  int stab_err = 0;
  logic        held = 1'b0;
  logic [12:0] h_addr = '0;
  logic [2:0]  h_data = '0;
  logic [31:0] wq[$];

  gpu_cpu_writer dut (
    .CLK_PIXEL (clk),
    .RST       (rst_n),
    .CE        (ce),
    .RW        (rw),
    .ADDR      (addr),
    .DATA      (data),
    .FB_ADDR   (fb_addr),
    .FB_DATA   (fb_data),
    .FB_WE     (fb_we),
    .FB_GNT    (fb_gnt),
    .BUSY      (busy),
    .OVERFLOW  (overflow)
  );

  always #5 clk = ~clk;

  // Record every accepted framebuffer write as addr*8+data.
  always @(posedge clk) begin
    if (rst_n && fb_we && fb_gnt) wq.push_back({16'd0, fb_addr, fb_data});
  end

  // Count any change of address/data while a request waits for its grant.
  always @(posedge clk) begin
    if (rst_n && held && fb_we && (fb_addr != h_addr || fb_data != h_data))
      stab_err <= stab_err + 1;
    if (rst_n && fb_we && !fb_gnt) begin
      held   <= 1'b1;
      h_addr <= fb_addr;
      h_data <= fb_data;
    end else begin
      held <= 1'b0;
    end
  end

  function automatic logic [31:0] key(input int a, input int d);
    return 32'(a * 8 + d);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (gnt_toggle) fb_gnt = ~fb_gnt;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [3:0] d);
    tick();
    addr = a;
    data = d;
    ce = 1'b0;
    rw = 1'b0;
    repeat (4) tick();
    ce = 1'b1;
    rw = 1'b1;
    repeat (4) tick();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int bad;
    int n_rst;

    // 1: reset values, three chars, cursor continues at 3
    repeat (3) tick();
    chk("rst_we",   {31'd0, fb_we}, 0);
    chk("rst_addr", {19'd0, fb_addr}, 0);
    chk("rst_data", {29'd0, fb_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ovf",  {31'd0, overflow}, 0);
    rst_n = 1'b1;
    fb_gnt = 1'b1;
    repeat (2) tick();
    cpu_write(2'd0, 4'd5);
    cpu_write(2'd0, 4'd2);
    cpu_write(2'd0, 4'hF);
    wait_idle("t1_busy_fall", 50);
    chk("t1_n",  wq.size(), 3);
    chk("t1_w0", wq[0], key(0, 5));
    chk("t1_w1", wq[1], key(1, 2));
    chk("t1_w2", wq[2], key(2, 7));
    cpu_write(2'd0, 4'd0);
    wait_idle("t1_busy2", 50);
    chk("t1_cursor3", wq[3], key(3, 0));

    // 2: load 0x1D4A -> SETCUR, then wrap past the last cell
    wq.delete();
    cpu_write(2'd1, 4'h1);
    cpu_write(2'd1, 4'hD);
    cpu_write(2'd1, 4'h4);
    cpu_write(2'd1, 4'hA);
    cpu_write(2'd2, 4'h3);
    cpu_write(2'd0, 4'd6);
    cpu_write(2'd0, 4'd1);
    cpu_write(2'd0, 4'd2);
    wait_idle("t2_busy", 50);
    chk("t2_n",  wq.size(), 3);
    chk("t2_w0", wq[0], key(7498, 6));
    chk("t2_w1", wq[1], key(7499, 1));
    chk("t2_w2", wq[2], key(0, 2));

    // 3: out-of-range load clamps the cursor to 0
    wq.delete();
    cpu_write(2'd1, 4'h1);
    cpu_write(2'd1, 4'hF);
    cpu_write(2'd1, 4'hF);
    cpu_write(2'd1, 4'hF);
    cpu_write(2'd2, 4'h3);
    cpu_write(2'd0, 4'd1);
    wait_idle("t3_busy", 50);
    chk("t3_n",  wq.size(), 1);
    chk("t3_w0", wq[0], key(0, 1));

    // 4: clear sweep with a toggling grant, then a char queued during the sweep
    wq.delete();
    cpu_write(2'd3, 4'd3);
`ifdef GPU_CLEAR_EN
    gnt_toggle = 1'b1;
    cpu_write(2'd2, 4'h1);
    cpu_write(2'd0, 4'd4);
    wait_idle("t4_busy", 20000);
    gnt_toggle = 1'b0;
    fb_gnt = 1'b1;
    chk("t4_n", wq.size(), 7501);
    bad = 0;
    for (int i = 0; i < 7500; i++) begin
      if (wq[i] !== key(i, 3)) bad++;
    end
    chk("t4_sweep_seq", bad, 0);
    chk("t4_char_after", wq[7500], key(0, 4));
    chk("t4_stable", stab_err, 0);
`else
    cpu_write(2'd2, 4'h1);
    wait_idle("t4_busy", 50);
    chk("t4_clear_noop", wq.size(), 0);
    cpu_write(2'd0, 4'd4);
    wait_idle("t4_busy2", 50);
    chk("t4_char_after", wq[0], key(1, 4));
`endif

    // 5: grant held low, six pushes -> one in WRITE, four queued, one dropped
    wq.delete();
    cpu_write(2'd2, 4'h2);
    wait_idle("t5_home", 50);
    fb_gnt = 1'b0;
    for (int i = 1; i <= 6; i++) cpu_write(2'd0, 4'(i));
    chk("t5_ovf",   {31'd0, overflow}, 1);
    chk("t5_busy",  {31'd0, busy}, 1);
    chk("t5_we",    {31'd0, fb_we}, 1);
    chk("t5_hold",  key(int'(fb_addr), int'(fb_data)), key(0, 1));
    chk("t5_none",  wq.size(), 0);
    tick();
    fb_gnt = 1'b1;
    wait_idle("t5_drain", 100);
    chk("t5_n", wq.size(), 5);
    for (int i = 0; i < 5; i++) chk("t5_w", wq[i], key(i, i + 1));
    chk("t5_stable", stab_err, 0);
    cpu_write(2'd2, 4'h4);
    wait_idle("t5_busy2", 50);
    chk("t5_ovf_clr", {31'd0, overflow}, 0);

    // 6: asynchronous reset in the middle of a long operation
    wq.delete();
`ifdef GPU_CLEAR_EN
    cpu_write(2'd2, 4'h1);
    repeat (300) tick();
`else
    fb_gnt = 1'b0;
    cpu_write(2'd0, 4'd5);
    repeat (5) tick();
`endif
    chk("t6_active", {31'd0, fb_we}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_we_async", {31'd0, fb_we}, 0);
    chk("t6_busy_async", {31'd0, busy}, 0);
    n_rst = wq.size();
    tick();
    rst_n = 1'b1;
    fb_gnt = 1'b1;
    repeat (50) tick();
    chk("t6_no_more", wq.size(), n_rst);
    chk("t6_idle", {31'd0, busy}, 0);
    cpu_write(2'd0, 4'd7);
    wait_idle("t6_busy", 50);
    chk("t6_cursor0", wq[n_rst], key(0, 7));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpu_cpu_writer.md
Name: gpu_cpu_writer

Overview:
CPU-side write front end for the character framebuffer in the new GPU. It synchronises raw 6502 bus strobes into the pixel clock domain and queues register writes in a small FIFO. An executor state machine then turns each queued write into a framebuffer write (cell address plus 3-bit sprite index) through a request/grant handshake. It also owns the text cursor, the fill value and a hardware clear-screen sweep.

Parameters:
CELLS, 7500, number of visible cells (100 x 75); cursor and clear range is 0..CELLS-1
ADDR_W, 13, framebuffer address width
DATA_W, 3, sprite index width written to the framebuffer
FIFO_DEPTH, 4, command FIFO entries (power of two)

Ports:
CLK_PIXEL  input  1  single block clock (pixel clock)
RST  input  1  asynchronous, active-low reset
CE  input  1  chip enable from CPU decode, active low, asynchronous to CLK_PIXEL
RW  input  1  CPU read/write, low = write, asynchronous
ADDR  input  2  register select, asynchronous
DATA  input  4  CPU data nibble, asynchronous
FB_ADDR  output  ADDR_W  framebuffer write address
FB_DATA  output  DATA_W  framebuffer write data
FB_WE  output  1  write request, held until granted
FB_GNT  input  1  framebuffer accepts the request in this cycle
BUSY  output  1  high when the FIFO is non-empty or the state is not IDLE
OVERFLOW  output  1  sticky: a CPU write was dropped

Behaviour:
- Reset: async assert on RST low. FB_WE=0, FB_ADDR=0, FB_DATA=0, BUSY=0, OVERFLOW=0; cursor=0, fill=0, load=0; FIFO empty; state IDLE. Reset mid-clear abandons the sweep.
- Input sync: CE, RW, ADDR and DATA each pass through 2 flops. wr = sync(~CE & ~RW). A rising edge of wr pushes {ADDR, DATA} into the FIFO. Push occurs 3 cycles after CE falls.
- CPU timing requirement: the CPU holds ADDR and DATA stable while CE is low. One push per CE assertion.
- FIFO full at push: the entry is dropped and OVERFLOW is set, even if a pop happens in the same cycle.
- Register map (applied in FIFO order):
  - ADDR 0, char: write DATA[2:0] at cursor; DATA[3] is ignored.
  - ADDR 1, load: load <= {load[8:0], DATA} (13-bit shift).
  - ADDR 2, command: 0x1 CLEAR, 0x2 HOME (cursor=0), 0x3 SETCUR (cursor=load if load<CELLS, else 0), 0x4 clear OVERFLOW; any other code is a no-op.
  - ADDR 3, fill: fill <= DATA[2:0].
- States:
  - IDLE: if the FIFO is non-empty, pop the head. Char goes to WRITE. CLEAR goes to CLEAR with sweep=0. All other ops complete in this cycle.
  - WRITE: FB_WE=1, FB_ADDR=cursor, FB_DATA=char. On FB_GNT: cursor increments (CELLS-1 wraps to 0), FB_WE=0, return to IDLE.
  - CLEAR: FB_WE=1, FB_ADDR=sweep, FB_DATA=fill. On FB_GNT, sweep increments. When the grant lands on sweep=CELLS-1: cursor=0, FB_WE=0, return to IDLE.
- FIFO keeps accepting pushes during CLEAR and WRITE; queued entries execute afterwards, in order.
- Handshake: FB_ADDR and FB_DATA are stable while FB_WE=1 and FB_GNT=0. At most one write is accepted per cycle.
- Minimum latency, push to FB_WE: 2 cycles (pop, then request).

Optional Feature:
GPU_CLEAR_EN
- Defined: the CLEAR command and CLEAR state exist as described above.
- Undefined: command 0x1 is a no-op, the CLEAR state and sweep counter are not built, and the fill register still loads but is unused.

Decomposition:
- Package gpu_pkg: CELLS, ADDR_W, DATA_W, register-select constants (REG_CHAR, REG_LOAD, REG_CMD, REG_FILL), command codes (CMD_CLEAR, CMD_HOME, CMD_SETCUR, CMD_CLROVF), state enum (IDLE, WRITE, CLEAR).
- One sub-module, gpu_cmd_fifo: synchronous FIFO with 6-bit entries, push/pop/full/empty.

Test Plan:
1. Reset, then 3 char writes 5, 2, 7 with FB_GNT tied high -> FB writes (0,5), (1,2), (2,7); cursor=3; BUSY falls after the last grant.
2. Load nibbles 1, D, 4, A, then SETCUR, then char 6 -> write at address 7498 (0x1D4A). Two more chars -> writes at 7499 then 0 (wrap).
3. Load 0x1FFF, then SETCUR, then char 1 -> write at address 0 (out-of-range load clamps to 0).
4. fill=3, CLEAR with FB_GNT toggling every other cycle -> exactly 7500 writes of value 3, addresses 0..7499 in order, each held until granted. A char 4 queued during the sweep is written at address 0 afterwards.
5. FB_GNT held low, 6 char pushes -> first pops into WRITE; FIFO fills with 4; the 6th is dropped and OVERFLOW=1. Release FB_GNT -> 5 writes land. Command 0x4 -> OVERFLOW=0.
6. Assert RST halfway through a CLEAR -> FB_WE=0 immediately (async). After release: IDLE, cursor=0, FIFO empty, and no further sweep writes.
